frac_mult_controller: RTL and testbench

//  Sequencer between the integer pipeline and fractionned_multiplier. Accepts one
//  RV32M multiply request (MUL/MULH/MULHSU/MULHU) via valid/ready, derives the

---
 rtl/frac_mult_controller.sv | 228 ++++++++++++++++++++++
 tb/tb_frac_mult_controller.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/frac_mult_controller.sv
// Sequencer that issues one RV32M multiply to fractionned_multiplier and returns the selected half.
// Optional last-operand result cache when MUL_OPERAND_CACHE_EN is defined.
module frac_mult_controller #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_error,
    output logic             busy,
    output logic [WIDTH-1:0] mult_input_a,
    output logic [WIDTH-1:0] mult_input_b,
    output logic             mult_signed_a,
    output logic             mult_signed_b,
    output logic             mult_enable,
    input  logic [WIDTH-1:0] mult_output_lower,
    input  logic [WIDTH-1:0] mult_output_higher,
    input  logic             mult_output_valid
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [1:0]  OP_MUL = 2'b00;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic              sa_q, sa_d, sb_q, sb_d;
    logic              en_q, en_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [WD_W-1:0]   wd_inc;
    logic              resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0]  resp_data_q, resp_data_d;
    logic              resp_error_q, resp_error_d;
    logic              req_ready_q, req_ready_d;
    logic              busy_q, busy_d;
    logic              req_sa, req_sb;

`ifdef MUL_OPERAND_CACHE_EN
    logic              c_valid_q, c_valid_d;
    logic [WIDTH-1:0]  c_a_q, c_a_d, c_b_q, c_b_d;
    logic              c_sa_q, c_sa_d, c_sb_q, c_sb_d;
    logic [WIDTH-1:0]  c_lo_q, c_lo_d, c_hi_q, c_hi_d;
    logic              c_hit;
`endif

    // MUL/MULH signed x signed, MULHSU signed x unsigned, MULHU unsigned x unsigned
    assign req_sa = (req_op != 2'b11);
    assign req_sb = ~req_op[1];
    assign wd_inc = wd_q + WD_W'(1);

`ifdef MUL_OPERAND_CACHE_EN
    // Low half of the product is signedness-independent, so MUL only needs operand equality
    assign c_hit = c_valid_q && (req_a == c_a_q) && (req_b == c_b_q) &&
                   ((req_op == OP_MUL) || ((req_sa == c_sa_q) && (req_sb == c_sb_q)));
`endif

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        sa_d         = sa_q;
        sb_d         = sb_q;
        en_d         = en_q;
        wd_d         = wd_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_error_d = resp_error_q;
        req_ready_d  = req_ready_q;
        busy_d       = busy_q;
`ifdef MUL_OPERAND_CACHE_EN
        c_valid_d    = c_valid_q;
        c_a_d        = c_a_q;
        c_b_d        = c_b_q;
        c_sa_d       = c_sa_q;
        c_sb_d       = c_sb_q;
        c_lo_d       = c_lo_q;
        c_hi_d       = c_hi_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    op_d        = req_op;
                    a_d         = req_a;
                    b_d         = req_b;
                    sa_d        = req_sa;
                    sb_d        = req_sb;
                    req_ready_d = 1'b0;
                    busy_d      = 1'b1;
`ifdef MUL_OPERAND_CACHE_EN
                    if (c_hit) begin
                        state_d      = S_DONE;
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b0;
                        resp_data_d  = (req_op == OP_MUL) ? c_lo_q : c_hi_q;
                    end else begin
                        state_d = S_ISSUE;
                        en_d    = 1'b1;
                    end
`else
                    state_d = S_ISSUE;
                    en_d    = 1'b1;
`endif
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                wd_d    = '0;
            end
            S_WAIT: begin
                if (mult_output_valid) begin
                    state_d      = S_DONE;
                    en_d         = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_error_d = 1'b0;
                    resp_data_d  = (op_q == OP_MUL) ? mult_output_lower : mult_output_higher;
`ifdef MUL_OPERAND_CACHE_EN
                    c_valid_d = 1'b1;
                    c_a_d     = a_q;
                    c_b_d     = b_q;
                    c_sa_d    = sa_q;
                    c_sb_d    = sb_q;
                    c_lo_d    = mult_output_lower;
                    c_hi_d    = mult_output_higher;
`endif
                end else if (wd_inc == WD_W'(TIMEOUT_CYCLES)) begin
                    state_d      = S_DONE;
                    en_d         = 1'b0;
                    wd_d         = wd_inc;
                    resp_valid_d = 1'b1;
                    resp_error_d = 1'b1;
                    resp_data_d  = '0;
`ifdef MUL_OPERAND_CACHE_EN
                    c_valid_d = 1'b0;
`endif
                end else begin
                    wd_d = wd_inc;
                end
            end
            S_DONE: begin
                if (resp_ready) begin
                    state_d      = S_IDLE;
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    busy_d       = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            sa_q         <= 1'b0;
            sb_q         <= 1'b0;
            en_q         <= 1'b0;
            wd_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_error_q <= 1'b0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
`ifdef MUL_OPERAND_CACHE_EN
            c_valid_q    <= 1'b0;
            c_a_q        <= '0;
            c_b_q        <= '0;
            c_sa_q       <= 1'b0;
            c_sb_q       <= 1'b0;
            c_lo_q       <= '0;
            c_hi_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sa_q         <= sa_d;
            sb_q         <= sb_d;
            en_q         <= en_d;
            wd_q         <= wd_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_error_q <= resp_error_d;
            req_ready_q  <= req_ready_d;
            busy_q       <= busy_d;
`ifdef MUL_OPERAND_CACHE_EN
            c_valid_q    <= c_valid_d;
            c_a_q        <= c_a_d;
            c_b_q        <= c_b_d;
            c_sa_q       <= c_sa_d;
            c_sb_q       <= c_sb_d;
            c_lo_q       <= c_lo_d;
            c_hi_q       <= c_hi_d;
`endif
        end
    end

    assign req_ready     = req_ready_q;
    assign busy          = busy_q;
    assign resp_valid    = resp_valid_q;
    assign resp_data     = resp_data_q;
    assign resp_error    = resp_error_q;
    assign mult_input_a  = a_q;
    assign mult_input_b  = b_q;
    assign mult_signed_a = sa_q;
    assign mult_signed_b = sb_q;
    assign mult_enable   = en_q;

endmodule

// File: tb/tb_frac_mult_controller.sv
// Directed + randomized bench for frac_mult_controller with a behavioural multiplier and product model.
module tb_frac_mult_controller;

    localparam int unsigned W   = 32;
    localparam int unsigned TMO = 64;

    logic          clock = 1'b0;
    logic          reset;
    logic          req_valid, req_ready, resp_valid, resp_ready, resp_error, busy;
    logic [1:0]    req_op;
    logic [W-1:0]  req_a, req_b, resp_data;
    logic [W-1:0]  mult_input_a, mult_input_b, mult_output_lower, mult_output_higher;
    logic          mult_signed_a, mult_signed_b, mult_enable, mult_output_valid;

    int checks = 0;
    int errors = 0;

    int  mdl_lat   = 1;
    bit  mdl_stall = 1'b0;
    int  m_cnt;
    logic [63:0] ext_a, ext_b, m_full;

    always #5 clock = ~clock;

    frac_mult_controller #(.WIDTH(W), .TIMEOUT_CYCLES(TMO)) dut (
        .clock              (clock),
        .reset              (reset),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_op             (req_op),
        .req_a              (req_a),
        .req_b              (req_b),
        .resp_valid         (resp_valid),
        .resp_ready         (resp_ready),
        .resp_data          (resp_data),
        .resp_error         (resp_error),
        .busy               (busy),
        .mult_input_a       (mult_input_a),
        .mult_input_b       (mult_input_b),
        .mult_signed_a      (mult_signed_a),
        .mult_signed_b      (mult_signed_b),
        .mult_enable        (mult_enable),
        .mult_output_lower  (mult_output_lower),
        .mult_output_higher (mult_output_higher),
        .mult_output_valid  (mult_output_valid)
    );

    // Multiplier stand-in: result valid after mdl_lat enabled cycles unless stalled
    always_comb begin
        ext_a  = mult_signed_a ? {{32{mult_input_a[31]}}, mult_input_a} : {32'b0, mult_input_a};
        ext_b  = mult_signed_b ? {{32{mult_input_b[31]}}, mult_input_b} : {32'b0, mult_input_b};
        m_full = ext_a * ext_b;
    end

    always_ff @(posedge clock) begin
        if (reset || !mult_enable) begin
            m_cnt             <= 0;
            mult_output_valid <= 1'b0;
        end else begin
            m_cnt              <= m_cnt + 1;
            mult_output_valid  <= !mdl_stall && (m_cnt + 1 >= mdl_lat);
            mult_output_lower  <= m_full[31:0];
            mult_output_higher <= m_full[63:32];
        end
    end

    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (op)
            2'b00:   p = sa * sb;
            2'b01:   p = sa * sb;
            2'b10:   p = sa * ub;
            default: p = ua * ub;
        endcase
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input bit stall, input int hold, input bit hit);
        logic [31:0] exp_d;
        int n;
        int exp_n;
        bit saw_en;
        exp_d     = stall ? 32'h0 : ref_mul(op, a, b);
        exp_n     = hit ? 1 : (stall ? int'(TMO) + 2 : lat + 2);
        mdl_lat   = lat;
        mdl_stall = stall;
        chk("req_ready_idle", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        tick();
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        req_a     = $urandom;
        req_b     = $urandom;
        n         = 1;
        saw_en    = mult_enable;
        chk("busy_after_accept", 64'(busy), 64'd1);
        chk("req_ready_after_accept", 64'(req_ready), 64'd0);
        if (!hit) begin
            chk("mult_enable_issue", 64'(mult_enable), 64'd1);
            chk("signed_a", 64'(mult_signed_a), 64'(op != 2'b11));
            chk("signed_b", 64'(mult_signed_b), 64'(!op[1]));
        end
        while (!resp_valid && n < int'(TMO) + 20) begin
            tick();
            n++;
            saw_en |= mult_enable;
            if (!resp_valid) chk("input_a_held", 64'(mult_input_a), 64'(a));
        end
        chk("latency", 64'(n), 64'(exp_n));
        chk("resp_data", 64'(resp_data), 64'(exp_d));
        chk("resp_error", 64'(resp_error), 64'(stall));
        chk("mult_enable_done", 64'(mult_enable), 64'd0);
        if (hit) chk("cache_no_enable", 64'(saw_en), 64'd0);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", 64'(resp_valid), 64'd1);
            chk("hold_data", 64'(resp_data), 64'(exp_d));
            chk("hold_req_ready", 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("resp_valid_drop", 64'(resp_valid), 64'd0);
        chk("req_ready_back", 64'(req_ready), 64'd1);
        chk("busy_clear", 64'(busy), 64'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        chk({tag, "_resp_error"}, 64'(resp_error), 64'd0);
        chk({tag, "_resp_data"}, 64'(resp_data), 64'd0);
        chk({tag, "_mult_enable"}, 64'(mult_enable), 64'd0);
        chk({tag, "_signed"}, 64'({mult_signed_a, mult_signed_b}), 64'd0);
        chk({tag, "_inputs"}, {mult_input_a, mult_input_b}, 64'd0);
    endtask

    initial begin
        bit hit;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_op     = 2'b00;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;
        tick();
        tick();
        chk_reset_vals("reset");
        reset = 1'b0;
        tick();

        run_op(2'b00, 32'd69, 32'd127, 1, 1'b0, 0, 1'b0);
        chk("mul_69_127", 64'(resp_data), 64'h0000_223B);
        run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 1'b0, 0, 1'b0);
        chk("mulhu_ones", 64'(resp_data), 64'hFFFF_FFFE);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 1'b0, 0, 1'b0);
        chk("mulh_ones", 64'(resp_data), 64'h0);
        run_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1'b0, 5, 1'b0);
        chk("mulhsu_ones", 64'(resp_data), 64'hFFFF_FFFF);

        run_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 1, 1'b1, 2, 1'b0);
        run_op(2'b00, 32'd7, 32'd9, 2, 1'b0, 0, 1'b0);

        // Reset asserted while the multiplier is stalled in WAIT
        mdl_stall = 1'b1;
        req_valid = 1'b1;
        req_op    = 2'b11;
        req_a     = 32'hDEAD_BEEF;
        req_b     = 32'h0000_0003;
        tick();
        req_valid = 1'b0;
        repeat (4) tick();
        chk("mid_wait_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        chk_reset_vals("async_reset");
        tick();
        chk_reset_vals("reset_edge");
        reset = 1'b0;
        tick();
        run_op(2'b11, 32'hDEAD_BEEF, 32'h0000_0003, 1, 1'b0, 0, 1'b0);

        run_op(2'b11, 32'd3, 32'd5, 2, 1'b0, 0, 1'b0);
`ifdef MUL_OPERAND_CACHE_EN
        hit = 1'b1;
`else
        hit = 1'b0;
`endif
        run_op(2'b00, 32'd3, 32'd5, 2, 1'b0, 1, hit);
        chk("cache_mul_3_5", 64'(resp_data), 64'h0000_000F);

        for (int i = 0; i < 10; i++) begin
            run_op(2'($urandom), $urandom, $urandom, int'($urandom_range(1, 4)), 1'b0,
                   int'($urandom_range(0, 2)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
